// File: rtl/mux_scanner.sv
// ---------------------------------------------------------------------------
// mux_scanner
//
// Purpose:
//    Walks a downstream 4:1 structural multiplexer through its four select
//    values. Each address is held for SETTLE_CYCLES clocks so the mux output
//    can settle before it is captured. The four captured bits are collected
//    in a shadow register and published together on 'sample', so a partially
//    finished scan is never visible to the consumer.
//
// Parameters:
//    SETTLE_CYCLES  clocks the address is held before capture (1..15)
//
// Ports:
//    clk       in   single clock, all state changes on the rising edge
//    reset     in   asynchronous, active-high reset
//    start     in   requests one scan; only looked at while idle
//    mux_out   in   output of the external 4:1 mux
//    address0  out  mux select LSB (registered)
//    address1  out  mux select MSB (registered)
//    sample    out  last completed scan, bit i = mux_out seen at address i
//    busy      out  high while a scan is in progress
//    done      out  one-cycle pulse when 'sample' is updated
//
// Configuration:
//    MUX_SCAN_CONTINUOUS_EN  when defined, a finished scan immediately starts
//                            the next one at address 0 (busy stays high and
//                            done still pulses once per scan) until reset.
// ---------------------------------------------------------------------------
module mux_scanner #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       mux_out,
   output logic       address0,
   output logic       address1,
   output logic [3:0] sample,
   output logic       busy,
   output logic       done
);

   // Reject settle values the 4-bit counter cannot represent.
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("mux_scanner: SETTLE_CYCLES must be in 1..15");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   // The counter starts at zero on entry to DRIVE and counts each DRIVE edge,
   // so the edge that sees LASTCOUNT is the SETTLE_CYCLES-th one.
   localparam logic [3:0] LASTCOUNT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] count;
   logic [1:0] addr;
   logic [2:0] shadow;

   // The select lines come straight from the address register so the mux
   // sees glitch-free, clock-aligned changes.
   assign address0 = addr[0];
   assign address1 = addr[1];

   // Scan sequencer. Every output is a register updated here; done defaults
   // low each edge so it can only ever be a single-cycle pulse. The channel-3
   // bit is taken straight from mux_out into 'sample' together with the
   // shadow bits, which is what makes the sample update atomic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= 4'd0;
         addr   <= 2'd0;
         shadow <= 3'b000;
         sample <= 4'b0000;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= DRIVE;
                  addr  <= 2'd0;
                  count <= 4'd0;
                  busy  <= 1'b1;
               end
            end

            DRIVE: begin
               count <= count + 4'd1;
               if (count == LASTCOUNT) begin
                  state <= CAPTURE;
               end
            end

            CAPTURE: begin
               count <= 4'd0;
               if (addr != 2'd3) begin
                  shadow[addr] <= mux_out;
                  addr         <= addr + 2'd1;
                  state        <= DRIVE;
               end else begin
                  sample <= {mux_out, shadow};
                  done   <= 1'b1;
                  addr   <= 2'd0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                  state  <= DRIVE;
                  busy   <= 1'b1;
`else
                  state  <= IDLE;
                  busy   <= 1'b0;
`endif
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               addr  <= 2'd0;
               count <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: clock cycles the address is held before mux_out is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one scan of all four mux channels; sampled only in IDLE.
REQ-005 mux_out  input  1  output of the downstream 4:1 structural multiplexer.
REQ-006 address0  output  1  mux select LSB, registered.
REQ-007 address1  output  1  mux select MSB, registered.
REQ-008 sample  output  4  last completed scan result; bit i = mux_out captured with address = i.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse marking scan completion and sample update.

Function
REQ-011 FSM states SHALL be IDLE, DRIVE and CAPTURE.
REQ-012 IDLE with start=1 at edge E0: go to DRIVE, set address to 0, clear settle counter, set busy=1.
REQ-013 IDLE with start=0: hold state; address, sample and busy unchanged; done=0.
REQ-014 DRIVE: increment settle counter each edge; hold address; after SETTLE_CYCLES edges in DRIVE, go to CAPTURE.
REQ-015 CAPTURE: store mux_out into shadow bit [address]; if address<3, increment address (address1:address0 as 2-bit count) and go to DRIVE with counter cleared.
REQ-016 CAPTURE at address=3: copy shadow bits 2..0 plus current mux_out into sample in one edge, pulse done=1, set busy=0, go to IDLE; address returns to 0.
REQ-017 Channel i SHALL be captured at edge E0+(i+1)*(SETTLE_CYCLES+1); done is high for the cycle after edge E0+4*(SETTLE_CYCLES+1).
REQ-018 sample SHALL change only at scan completion (atomic update); partial scans SHALL never be visible on sample.
REQ-019 start asserted while busy=1 SHALL be ignored, not queued.
REQ-020 start held high continuously SHALL cause a new scan to begin on the first edge after the done cycle in IDLE.
REQ-021 address SHALL only change on CAPTURE-to-DRIVE transitions or on reset, never during the settle window.

Reset
REQ-022 reset=1 SHALL immediately, without a clock, force state IDLE, address0=0, address1=0, sample=4'b0000, busy=0, done=0, and clear counter and shadow bits.
REQ-023 reset asserted mid-scan SHALL abort the scan; sample SHALL read 0 and no done pulse SHALL occur.
REQ-024 After reset deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-025 Macro MUX_SCAN_CONTINUOUS_EN: when defined, REQ-016 goes to DRIVE with address 0 instead of IDLE, busy stays 1 and done still pulses each scan, so scanning repeats without start until reset.
REQ-026 When MUX_SCAN_CONTINUOUS_EN is undefined, the block performs exactly one scan per accepted start, per REQ-016.

Verification
REQ-027 SETTLE_CYCLES=2, in0..in3=1,0,1,1, start pulse at E0 -> done high after edge E0+12, sample=4'b1101, busy=0 afterwards.
REQ-028 All inputs 0, start pulse -> sample=4'b0000, done pulses once; then in3=1 with a second start -> sample=4'b1000.
REQ-029 start re-pulsed at E0+5 during a scan -> ignored; exactly one done; sample unchanged until E0+12.
REQ-030 reset pulsed at E0+7 mid-scan with in=4'b1111 -> all outputs 0 asynchronously, no done pulse; a later start gives sample=4'b1111.
REQ-031 Monitor address1:address0 each cycle during a scan -> sequence 0,0,0,1,1,1,2,2,2,3,3,3 (SETTLE_CYCLES=2); mux_out checked stable at each capture.
REQ-032 MUX_SCAN_CONTINUOUS_EN defined, one start -> done every 12 cycles, busy stays 1; toggle in2 between scans -> sample bit 2 follows on the next done.
